// File: rtl/pipeline_defs_pkg.sv
// ============================================================================
// pipeline_defs : field positions, fetch FSM encoding and constants shared by
//                 the instruction fetch stage.   Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_defs;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int OP1_HI = 11;
  localparam int OP1_LO = 8;
  localparam int OP2_HI = 7;
  localparam int OP2_LO = 4;
  localparam int FC_HI  = 3;
  localparam int FC_LO  = 0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    TRAP   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [15:0] NOP_WORD           = 16'h0000;
  localparam logic [15:0] DEFAULT_EXC_VECTOR = 16'h0060;

  // Instructions are halfword aligned, so a redirect never lands on an odd byte.
  function automatic logic [15:0] align_target(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_register.sv
// ============================================================================
// if_id_register : IF/ID pipeline register with load / hold / flush control.
//                  Revision: 1.0
// ============================================================================
`default_nettype none

module if_id_register
  import pipeline_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [15:0] instr,
  input  logic [15:0] pc,
  output logic [3:0]  opcode,
  output logic [3:0]  op1,
  output logic [3:0]  op2,
  output logic [3:0]  function_code,
  output logic [15:0] if_id_pc,
  output logic        valid
);

  // Flush wins over load; neither asserted means hold every field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode        <= 4'h0;
      op1           <= 4'h0;
      op2           <= 4'h0;
      function_code <= 4'h0;
      if_id_pc      <= 16'h0000;
      valid         <= 1'b0;
    end else if (flush) begin
      opcode        <= NOP_WORD[OPC_HI:OPC_LO];
      op1           <= NOP_WORD[OP1_HI:OP1_LO];
      op2           <= NOP_WORD[OP2_HI:OP2_LO];
      function_code <= NOP_WORD[FC_HI:FC_LO];
      valid         <= 1'b0;
    end else if (load) begin
      opcode        <= instr[OPC_HI:OPC_LO];
      op1           <= instr[OP1_HI:OP1_LO];
      op2           <= instr[OP2_HI:OP2_LO];
      function_code <= instr[FC_HI:FC_LO];
      if_id_pc      <= pc;
      valid         <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit : IF stage owning the PC, redirect/trap/halt FSM and
//                          the IF/ID register.   Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
  import pipeline_defs::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
  parameter logic [15:0] PC_STEP    = 16'd2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [15:0] target,
  input  logic        halt,
  input  logic        overflow,
  output logic [3:0]  opcode,
  output logic [3:0]  op1,
  output logic [3:0]  op2,
  output logic [3:0]  function_code,
  output logic [15:0] if_id_pc,
  output logic        valid,
  output logic        halted,
  output logic [15:0] exc_pc
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic         redirect;
  logic         in_fetch;
  logic         ifid_load;
  logic         ifid_flush;

  assign imem_addr = pc;
  assign redirect  = branch_taken | jump;
  assign in_fetch  = (state == FETCH);

  // TRAP always inserts a bubble; in FETCH any event other than a bare stall kills the slot.
  assign ifid_flush = (state == TRAP) | (in_fetch & (overflow | halt | redirect));
  assign ifid_load  = in_fetch & ~overflow & ~halt & ~redirect & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      halted <= 1'b0;
      exc_pc <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (overflow) begin
            pc     <= EXC_VECTOR;
            exc_pc <= align_target(target);
            state  <= TRAP;
          end else if (halt) begin
            halted <= 1'b1;
            state  <= HALTED;
          end else if (redirect) begin
            pc <= align_target(target);
          end else if (!stall) begin
            pc <= pc + PC_STEP;
          end
        end
        TRAP:    state <= FETCH;
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

  if_id_register u_if_id (
    .clk           (clk),
    .reset         (reset),
    .load          (ifid_load),
    .flush         (ifid_flush),
    .instr         (imem_data),
    .pc            (pc),
    .opcode        (opcode),
    .op1           (op1),
    .op2           (op2),
    .function_code (function_code),
    .if_id_pc      (if_id_pc),
    .valid         (valid)
  );

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the 5-stage pipeline. Owns the PC and reads instruction memory.
- Drives the IF/ID register that feeds Opcode/FunctionCode into the control unit.
- Acts on the control unit's Branch/Jump/Halt outputs and the ALU Overflow flag by redirecting, flushing or freezing fetch.
- Instruction format, 16 bits: [15:12] opcode, [11:8] op1, [7:4] op2, [3:0] function code.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- EXC_VECTOR, 16'h0060, fetch address taken on arithmetic overflow.
- PC_STEP, 2, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  16  instruction memory address, equal to the PC.
- imem_data  input  16  instruction word; memory read is combinational from imem_addr.
- stall  input  1  hazard unit request to hold PC and IF/ID.
- branch_taken  input  1  resolved taken branch.
- jump  input  1  jump.
- target  input  16  redirect address, valid with branch_taken or jump.
- halt  input  1  halt instruction reached decode.
- overflow  input  1  ALU signed overflow on the instruction in EX.
- opcode  output  4  IF/ID opcode.
- op1  output  4  IF/ID op1 field.
- op2  output  4  IF/ID op2 field.
- function_code  output  4  IF/ID function code.
- if_id_pc  output  16  PC of the instruction held in IF/ID.
- valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch frozen by halt.
- exc_pc  output  16  PC of the last overflowing instruction (sticky).

Behaviour:
- Reset (async, any time, including mid-redirect):
  - PC=RESET_PC.
  - IF/ID fields=0, if_id_pc=0, valid=0.
  - halted=0, exc_pc=0, state=FETCH.
- FSM states: FETCH, TRAP, HALTED.
- FETCH, per rising edge, first matching rule wins:
  1. overflow: PC<=EXC_VECTOR, IF/ID flushed (valid<=0), exc_pc<=if_id_pc captured from the EX-stage copy supplied via target, state<=TRAP.
  2. halt: IF/ID flushed, PC holds, halted<=1, state<=HALTED.
  3. branch_taken or jump: PC<=target, IF/ID flushed. Net penalty is one bubble.
  4. stall: PC and IF/ID hold every field, valid unchanged.
  5. otherwise: IF/ID<=imem_data fields, if_id_pc<=PC, valid<=1, PC<=PC+PC_STEP.
- TRAP: lasts exactly one cycle.
  - Loads IF/ID with no instruction (valid=0); PC holds at EXC_VECTOR.
  - Returns to FETCH; the next cycle fetches from EXC_VECTOR.
  - All inputs are ignored in TRAP.
- HALTED: PC, IF/ID (valid=0) and halted=1 frozen. All inputs ignored. Only reset exits.
- Priority on simultaneous events:
  - overflow beats halt and redirect.
  - halt beats redirect; a jump in the same cycle as halt is discarded.
  - redirect beats stall, because the flushed slot is dead anyway.
- PC arithmetic: 16-bit unsigned, wraps 16'hFFFE -> 16'h0000 with no flag.
- target: bit 0 is forced to 0 on load.
- Latency: an instruction at PC appears on opcode/function_code one cycle after imem_addr=PC.
- imem_addr: combinational from the PC register, glitch-free.

Decomposition:
- Shared package (pipeline_defs):
  - Field bit positions (OPC_HI/LO, OP1, OP2, FC).
  - FSM state encodings: FETCH=2'd0, TRAP=2'd1, HALTED=2'd2.
  - NOP_WORD=16'h0000.
  - Default EXC_VECTOR.
- One natural sub-module: if_id_register, which holds the fields, PC and valid, with load/hold/flush controls.
- The PC/FSM logic stays in the top module.

Test Plan:
- Reset release with imem returning 16'h1AB0, 16'h1AB1 at addrs 0, 2 -> cycle 1 opcode=1, op1=A, op2=B, function_code=0, if_id_pc=0, valid=1; cycle 2 function_code=1, PC=4.
- jump=1, target=16'h0041 while fetching at 16'h0010 -> next edge valid=0, imem_addr=16'h0040; following edge if_id_pc=16'h0040.
- stall held 3 cycles at PC=16'h0008 -> imem_addr stays 16'h0008, IF/ID unchanged, valid unchanged; resumes at 16'h000A after release.
- overflow=1 together with halt=1 and jump=1 -> state TRAP, imem_addr=16'h0060, valid=0 for 2 cycles, halted=0, then if_id_pc=16'h0060.
- halt=1 -> halted=1 and valid=0 permanently; later jump, overflow and stall have no effect; assert reset mid-cycle -> immediate PC=0, halted=0.
- PC=16'hFFFE with no events -> next imem_addr=16'h0000, if_id_pc=16'hFFFE.
